// File: rtl/regfile_writeback_if.sv
// Writeback port bundle: ALU and load-unit results in, register-file write port and load status out.
// The slave modport is the writeback stage; the master modport is whoever drives the producers.
interface regfile_writeback_if;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        we3;
    logic [4:0]  wa3;
    logic [31:0] wd3;
    logic [31:0] pend_mask;
    logic [1:0]  ld_pending;

    modport master (
        output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
        input  ld_ready, we3, wa3, wd3, pend_mask, ld_pending
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
        output ld_ready, we3, wa3, wd3, pend_mask, ld_pending
    );
endinterface

// File: rtl/regfile_writeback.sv
// Register-file writeback arbiter: ALU results write immediately, load results queue in a
// 2-entry in-order FIFO and drain when the ALU leaves the write port free.
module regfile_writeback (
    input  logic               clk,
    input  logic               rst,
    regfile_writeback_if.slave bus
);
    logic [1:0]  r_count;
    logic [4:0]  r_rd   [2];
    logic [31:0] r_data [2];
    logic [1:0]  r_live;
    logic        r_we3;
    logic [4:0]  r_wa3;
    logic [31:0] r_wd3;

    logic        w_alu_wr;
    logic        w_ld_ready;
    logic        w_enq;
    logic        w_deq;
    logic [1:0]  w_live_cxl;
    logic [1:0]  w_occ;
    logic [1:0]  w_count_n;
    logic [4:0]  w_rd_n   [2];
    logic [31:0] w_data_n [2];
    logic [1:0]  w_live_n;
    logic [31:0] w_pend;

    // Entry 0 is always the FIFO head; a dequeue shifts entry 1 down.
    assign w_alu_wr   = bus.alu_valid && (bus.alu_rd != 5'd0);
    assign w_ld_ready = (r_count < 2'd2) && !rst;
    assign w_enq      = bus.ld_valid && w_ld_ready && (bus.ld_rd != 5'd0);
    assign w_deq      = !w_alu_wr && (r_count != 2'd0);
    assign w_occ      = {r_count == 2'd2, r_count != 2'd0};

    // An ALU write kills older buffered loads to the same register, including one arriving now.
    always_comb begin
        w_live_cxl = r_live;
        for (int i = 0; i < 2; i++) begin
            if (w_alu_wr && (r_rd[i] == bus.alu_rd)) begin
                w_live_cxl[i] = 1'b0;
            end
        end

        w_rd_n    = r_rd;
        w_data_n  = r_data;
        w_live_n  = w_live_cxl;
        w_count_n = r_count;

        if (w_deq) begin
            w_rd_n[0]   = r_rd[1];
            w_data_n[0] = r_data[1];
            w_live_n[0] = w_live_cxl[1];
            w_live_n[1] = 1'b0;
            w_count_n   = r_count - 2'd1;
        end

        if (w_enq) begin
            w_rd_n[w_count_n[0]]   = bus.ld_rd;
            w_data_n[w_count_n[0]] = bus.ld_data;
            w_live_n[w_count_n[0]] = !(w_alu_wr && (bus.ld_rd == bus.alu_rd));
            w_count_n              = w_count_n + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count   <= '0;
            r_live    <= '0;
            r_rd[0]   <= '0;
            r_rd[1]   <= '0;
            r_data[0] <= '0;
            r_data[1] <= '0;
        end else begin
            r_count   <= w_count_n;
            r_live    <= w_live_n;
            r_rd[0]   <= w_rd_n[0];
            r_rd[1]   <= w_rd_n[1];
            r_data[0] <= w_data_n[0];
            r_data[1] <= w_data_n[1];
        end
    end

    // A cancelled head still consumes its slot but leaves the port idle; address/data hold when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we3 <= 1'b0;
            r_wa3 <= '0;
            r_wd3 <= '0;
        end else if (w_alu_wr) begin
            r_we3 <= 1'b1;
            r_wa3 <= bus.alu_rd;
            r_wd3 <= bus.alu_data;
        end else if (w_deq && r_live[0]) begin
            r_we3 <= 1'b1;
            r_wa3 <= r_rd[0];
            r_wd3 <= r_data[0];
        end else begin
            r_we3 <= 1'b0;
        end
    end

    always_comb begin
        w_pend = '0;
        for (int i = 0; i < 2; i++) begin
            if (w_occ[i] && r_live[i]) begin
                w_pend[r_rd[i]] = 1'b1;
            end
        end
        w_pend[0] = 1'b0;
    end

    assign bus.ld_ready   = w_ld_ready;
    assign bus.we3        = r_we3;
    assign bus.wa3        = r_wa3;
    assign bus.wd3        = r_wd3;
    assign bus.pend_mask  = w_pend;
    assign bus.ld_pending = r_count;
endmodule

// File: doc/regfile_writeback.md
REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 alu_valid  input  1  ALU result present this cycle; no backpressure, always accepted.
REQ-004 alu_rd  input  5  ALU destination register.
REQ-005 alu_data  input  32  ALU result.
REQ-006 ld_valid  input  1  load-unit result offered.
REQ-007 ld_ready  output  1  load result accepted when ld_valid && ld_ready at a rising edge.
REQ-008 ld_rd  input  5  load destination register.
REQ-009 ld_data  input  32  load result.
REQ-010 we3  output  1  register-file write enable, registered.
REQ-011 wa3  output  5  register-file write address, registered.
REQ-012 wd3  output  32  register-file write data, registered.
REQ-013 pend_mask  output  32  bit r = 1 when a live (non-cancelled) buffered load targets register r; bit 0 always 0.
REQ-014 ld_pending  output  2  count of occupied load-buffer entries (0..2), live or cancelled.

Function
REQ-015 Load buffer SHALL be a 2-entry in-order FIFO; each entry holds rd, data, live flag.
REQ-016 ld_ready SHALL equal (count < 2) && !rst, decoded from registered count only; no enqueue when full even if dequeuing same cycle.
REQ-017 Accepted load with ld_rd == 0 SHALL complete the handshake but not be enqueued.
REQ-018 Write-port arbitration per cycle: alu_valid with alu_rd != 0 wins; otherwise FIFO head (if any) is selected.
REQ-019 ALU result at cycle N SHALL appear as we3=1, wa3=alu_rd, wd3=alu_data in cycle N+1.
REQ-020 alu_valid with alu_rd == 0 SHALL produce we3=0 next cycle and SHALL NOT block the FIFO head that cycle.
REQ-021 FIFO head selected in cycle M SHALL be dequeued at the end of M; if live, we3=1/wa3/wd3 from the entry in M+1; if cancelled, we3=0 in M+1.
REQ-022 Minimum load latency: accepted at edge ending cycle N, empty FIFO, no ALU in N+1 -> we3=1 in N+2.
REQ-023 WAW ordering: alu_valid with alu_rd = r != 0 SHALL clear the live flag of every buffered entry with rd = r, including a load enqueued in the same cycle (same-cycle load is treated as older).
REQ-024 When no write is selected, we3 SHALL be 0; wa3/wd3 SHALL hold their previous values.
REQ-025 Loads SHALL wait indefinitely under continuous ALU traffic; no starvation guard.
REQ-026 pend_mask and ld_pending SHALL be derived from registered state only (no input-to-output combinational path).

Reset
REQ-027 While rst is high: we3=0, wa3=0, wd3=0, FIFO empty, ld_pending=0, pend_mask=0, ld_ready=0, asynchronously.
REQ-028 Reset mid-operation SHALL discard all buffered loads without writing them; first write possible in cycle after rst deasserts.

Verification
REQ-029 ALU only: alu_valid, rd=5, data=0x1234_5678 at cycle 1 -> cycle 2 we3=1, wa3=5, wd3=0x1234_5678; ld_pending=0.
REQ-030 Load only: ld rd=7, data=0xDEAD_BEEF accepted cycle 1, no ALU -> pend_mask=0x80 in cycle 2; cycle 3 we3=1, wa3=7; pend_mask=0 in cycle 3.
REQ-031 Full/backpressure: loads rd=1,2 accepted with alu_valid held (rd=9) -> ld_pending=2, ld_ready=0; third load stalls; drop alu_valid -> writes rd1 then rd2 on consecutive cycles, ld_ready returns 1 after first dequeue.
REQ-032 WAW cancel: load rd=3 data=0xA buffered, ALU rd=3 data=0xB same or later cycle -> exactly one write to x3 with 0xB; cancelled entry yields we3=0 slot; pend_mask bit3=0 after ALU edge.
REQ-033 x0: ALU rd=0 and load rd=0 -> we3 never 1 for wa3=0; load handshake completes; ld_pending unchanged.
REQ-034 Async reset with 2 entries buffered: rst asserted mid-cycle -> outputs cleared immediately, no subsequent write of buffered data after release.
